mxv_engine_param: RTL and testbench

- Parametrised successor to the fixed four-processor matrix-vector datapath.
- Accepts a byte-serial frame on the rcv/data interface: header, then a row-major matrix, then a vector. Computes y = M·v on LANES parallel MAC lanes.
- Streams the results out through an internal result FIFO with a valid/ready handshake.
- Sits directly behind the UART receiver in the mxv subsystem and replaces the separate controller and datapath pair.

---
 rtl/mxv_pkg.sv | 20 ++
 rtl/mxv_result_fifo.sv | 61 ++++++
 rtl/mxv_engine_param.sv | 199 +++++++++++++++++++
 tb/tb_mxv_engine_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mxv_pkg.sv
// Shared types and defaults for the mxv matrix-vector engine.
package mxv_pkg;

  localparam int MXV_N     = 4;
  localparam int MXV_LANES = 2;
  localparam int MXV_DW    = 8;
  localparam int MXV_RW    = 2 * MXV_DW + $clog2(MXV_N);

  typedef logic [MXV_DW-1:0] mxv_elem_t;
  typedef logic [MXV_RW-1:0] mxv_result_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_M,
    ST_LOAD_V,
    ST_COMPUTE,
    ST_WRITE
  } mxv_eng_state_e;

endpackage

// File: rtl/mxv_result_fifo.sv
// Result FIFO with registered storage; out data reads as zero while empty.
module mxv_result_fifo
  import mxv_pkg::*;
#(
  parameter int W     = MXV_RW,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] pop_data
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full     = (count_q == CNTW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mxv_engine_param.sv
// Byte-serial matrix-vector engine: loads M and v, computes y = M*v on LANES MAC lanes.
// state      | meaning
// IDLE       | waiting for header byte N_act
// LOAD_M     | storing N_act*N_act matrix bytes, row-major
// LOAD_V     | storing N_act vector bytes
// COMPUTE    | one MAC per lane per cycle over k = 0..N_act-1
// WRITE      | pushing valid lane results of the group into the FIFO
module mxv_engine_param
  import mxv_pkg::*;
#(
  parameter int N     = MXV_N,
  parameter int LANES = MXV_LANES,
  parameter int DW    = MXV_DW,
  parameter int DEPTH = 8,
  parameter int RW    = 2 * DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rcv,
  input  logic [DW-1:0] data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [RW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int CW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  mxv_eng_state_e state_q, state_d;
  logic [CW-1:0]  n_act_q, n_act_d, r_q, r_d, c_q, c_d, k_q, k_d, g_q, g_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic           busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic [DW-1:0]  mat_q [N][N];
  logic [DW-1:0]  vec_q [N];
  logic           mat_we, vec_we, header_ok;
  logic [CW-1:0]  n_last, row_base, wr_row;
  logic [RW-1:0]  lane_res [LANES];
  logic           fifo_push, fifo_full, fifo_empty;

  assign header_ok = (data != '0) && (int'(data) <= N);
  assign n_last    = n_act_q - CW'(1);
  assign row_base  = g_q * CW'(LANES);
  assign wr_row    = row_base + CW'(lane_q);

  always_comb begin
    state_d   = state_q;
    n_act_d   = n_act_q;
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    g_d       = g_q;
    lane_d    = lane_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    mat_we    = 1'b0;
    vec_we    = 1'b0;
    fifo_push = 1'b0;
    case (state_q)
      ST_IDLE: if (rcv) begin
        if (header_ok) begin
          n_act_d = CW'(data);
          r_d     = '0;
          c_d     = '0;
          state_d = ST_LOAD_M;
        end else begin
          error_d = 1'b1;
        end
      end
      ST_LOAD_M: if (rcv) begin
        mat_we = 1'b1;
        if (c_q == n_last) begin
          c_d = '0;
          if (r_q == n_last) begin
            r_d     = '0;
            state_d = ST_LOAD_V;
          end else begin
            r_d = r_q + CW'(1);
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      ST_LOAD_V: if (rcv) begin
        vec_we = 1'b1;
        if (c_q == n_last) begin
          c_d     = '0;
          g_d     = '0;
          k_d     = '0;
          state_d = ST_COMPUTE;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      ST_COMPUTE: begin
        error_d = rcv;
        if (k_q == n_last) begin
          k_d     = '0;
          lane_d  = '0;
          state_d = ST_WRITE;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      ST_WRITE: begin
        error_d = rcv;
        // Full is judged before any same-cycle pop, so a full FIFO always stalls here.
        if (!fifo_full) begin
          fifo_push = 1'b1;
          if (wr_row == n_last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (lane_q == LW'(LANES - 1)) begin
            g_d     = g_q + CW'(1);
            k_d     = '0;
            state_d = ST_COMPUTE;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_act_q <= '0;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      g_q     <= '0;
      lane_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_act_q <= n_act_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      g_q     <= g_d;
      lane_q  <= lane_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mat_we) mat_q[r_q[IW-1:0]][c_q[IW-1:0]] <= data;
    if (vec_we) vec_q[c_q[IW-1:0]] <= data;
  end

  // Lanes past N_act still accumulate stale data; WRITE never pushes them.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [IW-1:0] row;
    logic [RW-1:0] prod, acc_q, acc_d;

    assign row  = row_base[IW-1:0] + IW'(j);
    assign prod = RW'(mat_q[row][k_q[IW-1:0]]) * RW'(vec_q[k_q[IW-1:0]]);

    always_comb begin
      acc_d = acc_q;
      if (state_q == ST_COMPUTE) acc_d = ((k_q == '0) ? '0 : acc_q) + prod;
    end

    always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
    end

    assign lane_res[j] = acc_q;
  end

  mxv_result_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (lane_res[lane_q]),
    .pop       (out_valid && out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .pop_data  (out_data)
  );

  assign out_valid = !fifo_empty;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_mxv_engine_param.sv
// Scoreboard bench for mxv_engine_param with a two-entry result FIFO.
module tb_mxv_engine_param;

  localparam int N     = 4;
  localparam int LANES = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int RW    = 2 * DW + $clog2(N);

  logic          clk = 1'b0;
  logic          rst, rcv, out_ready;
  logic [DW-1:0] data;
  logic          out_valid, busy, done, error;
  logic [RW-1:0] out_data;

  int n_checks = 0, n_errors = 0;
  int done_cnt = 0, err_cnt = 0, pop_cnt = 0;
  logic [RW-1:0] exp_q [$];

  always #5 clk = ~clk;

  mxv_engine_param #(.N(N), .LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rcv       (rcv),
    .data      (data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done)  done_cnt++;
      if (error) err_cnt++;
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("extra_pop", 1, 0);
        else                   check("result", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rcv  = 1'b1;
    data = b;
    tick(1);
    rcv  = 1'b0;
    data = '0;
  endtask

  task automatic send_frame(input int n, input int m[16], input int v[4]);
    for (int r = 0; r < n; r++) begin
      int y = 0;
      for (int c = 0; c < n; c++) y += m[r*4+c] * v[c];
      exp_q.push_back(RW'(y));
    end
    send_byte(8'(n));
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) send_byte(8'(m[r*4+c]));
    for (int c = 0; c < n; c++) send_byte(8'(v[c]));
  endtask

  task automatic wait_done(input int max);
    int c = 0;
    while (!done && c < max) begin
      tick(1);
      c++;
    end
    check("done_seen", done, 1);
    tick(1);
  endtask

  task automatic wait_drain(input int max);
    int c = 0;
    while (exp_q.size() != 0 && c < max) begin
      tick(1);
      c++;
    end
    check("drained", exp_q.size(), 0);
    tick(2);
    check("fifo_idle_empty", out_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m[16], v[4];
    int d0, e0, p0, lat_v, lat_d, n;

    rst = 1'b1; rcv = 1'b0; data = '0; out_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_data", out_data, 0);

    // identity with latency checks
    foreach (m[i]) m[i] = (i % 5 == 0) ? 1 : 0;
    v = '{1, 2, 3, 4};
    d0 = done_cnt; e0 = err_cnt;
    send_frame(4, m, v);
    lat_v = -1; lat_d = -1;
    for (int c = 0; c < 40 && lat_d < 0; c++) begin
      if (out_valid && lat_v < 0) lat_v = c;
      if (done) lat_d = c;
      tick(1);
    end
    check("lat_first_valid", lat_v, 5);
    check("lat_done", lat_d, 12);
    wait_drain(50);
    check("ident_done_once", done_cnt - d0, 1);
    check("ident_no_error", err_cnt - e0, 0);

    // maximum values
    foreach (m[i]) m[i] = 255;
    v = '{255, 255, 255, 255};
    send_frame(4, m, v);
    wait_done(60);
    wait_drain(50);

    // partial group
    m = '{1, 2, 3, 0, 4, 5, 6, 0, 7, 8, 9, 0, 0, 0, 0, 0};
    v = '{1, 1, 1, 0};
    p0 = pop_cnt;
    send_frame(3, m, v);
    wait_done(60);
    wait_drain(50);
    check("partial_pops", pop_cnt - p0, 3);

    // backpressure
    foreach (m[i]) m[i] = (i % 5 == 0) ? 1 : 0;
    v = '{1, 2, 3, 4};
    out_ready = 1'b0;
    d0 = done_cnt; p0 = pop_cnt;
    send_frame(4, m, v);
    tick(30);
    check("bp_busy", busy, 1);
    check("bp_valid", out_valid, 1);
    check("bp_no_done", done_cnt - d0, 0);
    check("bp_no_pop", pop_cnt - p0, 0);
    out_ready = 1'b1;
    wait_done(60);
    wait_drain(50);
    check("bp_done_once", done_cnt - d0, 1);

    // protocol errors
    e0 = err_cnt;
    send_byte(8'd0);
    tick(2);
    check("hdr0_error", err_cnt - e0, 1);
    check("hdr0_idle", busy, 0);
    send_byte(8'd5);
    tick(2);
    check("hdr5_error", err_cnt - e0, 2);
    check("hdr5_idle", busy, 0);
    send_frame(4, m, v);
    tick(2);
    send_byte(8'hAA);
    wait_done(60);
    wait_drain(50);
    check("compute_rcv_error", err_cnt - e0, 3);

    // reset mid LOAD_M after seven bytes
    send_byte(8'd4);
    for (int i = 0; i < 7; i++) send_byte(8'(i + 9));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    foreach (m[i]) m[i] = $urandom_range(0, 255);
    foreach (v[i]) v[i] = $urandom_range(0, 255);
    send_frame(4, m, v);
    wait_done(60);
    wait_drain(50);

    // random frames of random size
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 4);
      foreach (m[i]) m[i] = $urandom_range(0, 255);
      foreach (v[i]) v[i] = $urandom_range(0, 255);
      send_frame(n, m, v);
      wait_done(60);
      wait_drain(50);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
